// File: rtl/rggen_spi_slave_engine.sv
// SPI slave protocol engine (mode 0, MSB first, oversampled in i_clk).
// Decodes one SPI frame into one rggen bus transaction.
//   Frame: cmd(8) addr(8*ADDR_BYTES) then
//     write: wdata(BUS_WIDTH) status(8 out)
//     read : turnaround(8) status(8 out) rdata(BUS_WIDTH out)
//   Status byte = {done, 5'b0, status}; zero if the response was late.
// Ports:
//   i_clk/i_rst              system clock, async active-high reset
//   i_sclk/i_ss_n/i_mosi     SPI inputs (asynchronous)
//   o_miso/o_miso_en         SPI output and its enable
//   o_bus_* / i_bus_*        request/response to rggen_adapter_common
module rggen_spi_slave_engine #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int SYNC_STAGES   = 2
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_sclk,
  input  logic                     i_ss_n,
  input  logic                     i_mosi,
  output logic                     o_miso,
  output logic                     o_miso_en,
  output logic                     o_bus_valid,
  output logic [1:0]               o_bus_access,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [BUS_WIDTH-1:0]     o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_bus_strobe,
  input  logic                     i_bus_ready,
  input  logic [1:0]               i_bus_status,
  input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);
  localparam int ADDR_BYTES = (ADDRESS_WIDTH + 7) / 8;
  localparam int ADDR_BITS  = 8 * ADDR_BYTES;
  localparam int RX_W       = (BUS_WIDTH > ADDR_BITS) ? BUS_WIDTH : ADDR_BITS;
  localparam int CNT_W      = $clog2(RX_W + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, TURN, STAT, RDATA, DRAIN} state_t;

  // ---------------- input synchronizers / edge detect ----------------
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_q, ss_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], i_ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      ss_q      <= ss_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ss_s, mosi_s, rise, fall, ss_fall, ss_rise;
  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign ss_s    = ss_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_q;
  assign fall    = ~sclk_s & sclk_q;
  assign ss_fall = ss_q & ~ss_s;
  assign ss_rise = ~ss_q & ss_s;
  assign o_miso_en = ~ss_s;

  // ---------------- frame FSM ----------------
  state_t state_q, state_nxt;
  logic [CNT_W-1:0] bit_cnt, field_len;
  logic [RX_W-1:0]  rx_shift, rx_next;
  logic counted, field_done, issue_now, load_stat, load_rdata, shift_tx;
  logic is_write, cmd_ok;

  assign rx_next = {rx_shift[RX_W-2:0], mosi_s};
  assign cmd_ok  = (rx_next[7:0] == 8'h02) || (rx_next[7:0] == 8'h03);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (ss_rise) state_nxt = IDLE;
    else begin
      case (state_q)
        IDLE:  if (ss_fall)    state_nxt = CMD;
        CMD:   if (field_done) state_nxt = cmd_ok ? ADDR : DRAIN;
        ADDR:  if (field_done) state_nxt = is_write ? WDATA : TURN;
        WDATA: if (field_done) state_nxt = STAT;
        TURN:  if (field_done) state_nxt = STAT;
        STAT:  if (field_done) state_nxt = is_write ? DRAIN : RDATA;
        RDATA: if (field_done) state_nxt = DRAIN;
        default: state_nxt = state_q;
      endcase
    end
  end

  always_comb begin
    field_len = '0;
    counted   = 1'b1;
    case (state_q)
      CMD, TURN, STAT: field_len = CNT_W'(8);
      ADDR:            field_len = CNT_W'(ADDR_BITS);
      WDATA, RDATA:    field_len = CNT_W'(BUS_WIDTH);
      default:         counted   = 1'b0;
    endcase
    field_done = rise && counted && (bit_cnt == field_len - 1'b1);
    issue_now  = field_done && !ss_rise &&
                 (((state_q == ADDR) && !is_write) || (state_q == WDATA));
    // First fall of an output field (no rise counted yet) loads the shifter,
    // so the MSB is on the wire before the master's first sampling rise.
    load_stat  = fall && (state_q == STAT)  && (bit_cnt == '0);
    load_rdata = fall && (state_q == RDATA) && (bit_cnt == '0);
    shift_tx   = fall && ((state_q == STAT) || (state_q == RDATA)) && (bit_cnt != '0);
  end

  logic [ADDRESS_WIDTH-1:0] frame_addr;
  logic [BUS_WIDTH-1:0]     frame_wdata;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      is_write    <= 1'b0;
      frame_addr  <= '0;
      frame_wdata <= '0;
    end else begin
      if (state_q != state_nxt)  bit_cnt <= '0;
      else if (rise && counted)  bit_cnt <= bit_cnt + 1'b1;
      if (rise) rx_shift <= rx_next;
      if ((state_q == CMD) && field_done)   is_write    <= (rx_next[7:0] == 8'h02);
      if ((state_q == ADDR) && field_done)  frame_addr  <= rx_next[ADDRESS_WIDTH-1:0];
      if ((state_q == WDATA) && field_done) frame_wdata <= rx_next[BUS_WIDTH-1:0];
    end
  end

  // ---------------- bus side ----------------
  // issue_pend holds a request while an aborted frame's transaction is still
  // outstanding. bus_live marks the outstanding transaction as owned by the
  // current frame; an abort clears it so the response is dropped.
  logic issue_pend, bus_live, bus_load, capture, done;
  logic [1:0]           resp_status;
  logic [BUS_WIDTH-1:0] resp_rdata;

  assign bus_load = !o_bus_valid && !ss_rise && (issue_now || issue_pend);
  assign capture  = o_bus_valid && i_bus_ready && bus_live && !ss_rise;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bus_valid      <= 1'b0;
      o_bus_access     <= '0;
      o_bus_address    <= '0;
      o_bus_write_data <= '0;
      o_bus_strobe     <= '0;
      issue_pend       <= 1'b0;
      bus_live         <= 1'b0;
      done             <= 1'b0;
      resp_status      <= '0;
      resp_rdata       <= '0;
    end else begin
      issue_pend <= !ss_rise && (issue_pend || issue_now) && !bus_load;
      if (ss_rise)                         bus_live <= 1'b0;
      else if (bus_load)                   bus_live <= 1'b1;
      else if (o_bus_valid && i_bus_ready) bus_live <= 1'b0;

      if (o_bus_valid) begin
        if (i_bus_ready) o_bus_valid <= 1'b0;
      end else if (bus_load) begin
        o_bus_valid      <= 1'b1;
        o_bus_access     <= is_write ? 2'b11 : 2'b10;
        o_bus_address    <= (issue_now && !is_write) ? rx_next[ADDRESS_WIDTH-1:0] : frame_addr;
        o_bus_write_data <= !is_write ? '0 :
                            issue_now ? rx_next[BUS_WIDTH-1:0] : frame_wdata;
        o_bus_strobe     <= is_write ? '1 : '0;
      end

      if ((state_q == IDLE) && ss_fall) begin
        done        <= 1'b0;
        resp_status <= '0;
        resp_rdata  <= '0;
      end else if (capture) begin
        done        <= 1'b1;
        resp_status <= i_bus_status;
        if (!o_bus_access[0]) resp_rdata <= i_bus_read_data;
      end
    end
  end

  // ---------------- MISO shifter ----------------
  logic [BUS_WIDTH-1:0] tx_shift, rd_word;
  logic [7:0]           stat_byte;
  logic                 stat_done;
  assign stat_byte = done ? {1'b1, 5'b0, resp_status} : 8'h00;
  // Read data is only returned if the status byte already reported done.
  assign rd_word   = stat_done ? resp_rdata : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_miso    <= 1'b0;
      tx_shift  <= '0;
      stat_done <= 1'b0;
    end else if (load_stat) begin
      o_miso    <= stat_byte[7];
      tx_shift  <= {stat_byte[6:0], {(BUS_WIDTH-7){1'b0}}};
      stat_done <= done;
    end else if (load_rdata) begin
      o_miso    <= rd_word[BUS_WIDTH-1];
      tx_shift  <= {rd_word[BUS_WIDTH-2:0], 1'b0};
    end else if (shift_tx) begin
      o_miso    <= tx_shift[BUS_WIDTH-1];
      tx_shift  <= {tx_shift[BUS_WIDTH-2:0], 1'b0};
    end else if (fall || (state_q == IDLE)) begin
      o_miso    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rggen_spi_slave_engine.sv
// Bench for rggen_spi_slave_engine: SPI master tasks, a bus responder, and a
// scoreboard of expected bus requests derived from the frame bytes.
module tb_rggen_spi_slave_engine;
  logic        i_clk = 1'b0, i_rst, i_sclk, i_ss_n, i_mosi;
  logic        o_miso, o_miso_en, o_bus_valid, i_bus_ready;
  logic [1:0]  o_bus_access, i_bus_status;
  logic [7:0]  o_bus_address;
  logic [31:0] o_bus_write_data, i_bus_read_data;
  logic [3:0]  o_bus_strobe;

  rggen_spi_slave_engine #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sclk(i_sclk), .i_ss_n(i_ss_n), .i_mosi(i_mosi),
    .o_miso(o_miso), .o_miso_en(o_miso_en), .o_bus_valid(o_bus_valid),
    .o_bus_access(o_bus_access), .o_bus_address(o_bus_address),
    .o_bus_write_data(o_bus_write_data), .o_bus_strobe(o_bus_strobe),
    .i_bus_ready(i_bus_ready), .i_bus_status(i_bus_status), .i_bus_read_data(i_bus_read_data));

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [1:0]  acc;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  int checks = 0, errors = 0, txn_count = 0;
  int resp_delay = 2;
  logic [1:0]  resp_status = 2'b00;
  logic [31:0] resp_rdata = '0;
  logic [1:0]  last_acc;
  logic [7:0]  last_addr;
  logic [3:0]  last_strb;
  logic [31:0] last_wdata;
  logic [7:0]  fb [8];
  logic [63:0] mbits;
  logic        en_mid;
  req_t        exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Spec-level model of the request a frame produces.
  function automatic req_t model_req(input logic [7:0] b [8]);
    req_t r;
    r.acc   = (b[0] == 8'h02) ? 2'b11 : 2'b10;
    r.addr  = b[1];
    r.wdata = (b[0] == 8'h02) ? {b[2], b[3], b[4], b[5]} : 32'h0;
    r.strb  = (b[0] == 8'h02) ? 4'hF : 4'h0;
    return r;
  endfunction

  function automatic logic [7:0] status_byte(input logic done, input logic [1:0] st);
    return done ? {1'b1, 5'b0, st} : 8'h00;
  endfunction

  // Scoreboard: every valid cycle must present the head expected request.
  logic prev_v = 1'b0;
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_v = 1'b0;
      exp_q.delete();
    end else begin
      if (o_bus_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 64'(o_bus_valid), 64'd0);
        else chk("bus_req",
                 64'({o_bus_access, o_bus_address,
                      (exp_q[0].acc == 2'b11) ? o_bus_write_data : 32'h0, o_bus_strobe}),
                 64'(exp_q[0]));
      end
      if (prev_v && !o_bus_valid && exp_q.size() > 0) void'(exp_q.pop_front());
      prev_v = o_bus_valid;
    end
  end

  // Bus responder: delay, status and data latched when the request appears.
  initial begin
    i_bus_ready = 1'b0; i_bus_status = '0; i_bus_read_data = '0;
    forever begin
      @(negedge i_clk);
      if (o_bus_valid && !i_rst) begin
        int lim, d;
        logic [1:0]  st;
        logic [31:0] rd;
        lim = resp_delay; st = resp_status; rd = resp_rdata; d = 0;
        while (d < lim && o_bus_valid && !i_rst) begin @(negedge i_clk); d++; end
        if (o_bus_valid && !i_rst) begin
          last_acc = o_bus_access; last_addr = o_bus_address;
          last_wdata = o_bus_write_data; last_strb = o_bus_strobe;
          i_bus_status = st; i_bus_read_data = rd; i_bus_ready = 1'b1;
          @(negedge i_clk);
          i_bus_ready = 1'b0;
          txn_count++;
        end
      end
    end
  end

  // SPI master, mode 0: 16 i_clk per SCLK period; miso sampled just before each rise.
  task automatic send_frame(input int nbits);
    i_ss_n = 1'b0;
    repeat (8) @(negedge i_clk);
    mbits = '0;
    for (int i = 0; i < nbits; i++) begin
      i_mosi = fb[i/8][7-(i%8)];
      repeat (8) @(negedge i_clk);
      mbits = {mbits[62:0], o_miso};
      if (i == 0) en_mid = o_miso_en;
      i_sclk = 1'b1;
      repeat (8) @(negedge i_clk);
      i_sclk = 1'b0;
    end
    repeat (8) @(negedge i_clk);
    i_ss_n = 1'b1; i_mosi = 1'b0;
    repeat (8) @(negedge i_clk);
  endtask

  task automatic set_fb(input logic [63:0] v);
    for (int i = 0; i < 8; i++) fb[i] = v[63-8*i -: 8];
  endtask

  task automatic wait_txns(input int n, input string nm);
    int t = 0;
    while (txn_count < n && t < 3000) begin @(negedge i_clk); t++; end
    chk(nm, 64'(txn_count), 64'(n));
  endtask

  task automatic read_frame(input logic [63:0] bytes, input int dly, input logic [1:0] st,
                            input logic [31:0] rd, input logic done_exp, input string nm);
    set_fb(bytes);
    resp_delay = dly; resp_status = st; resp_rdata = rd;
    exp_q.push_back(model_req(fb));
    send_frame(64);
    chk({nm, "_en"}, 64'(en_mid), 64'd1);
    chk({nm, "_status"}, 64'(mbits[39:32]), 64'(status_byte(done_exp, st)));
    chk({nm, "_rdata"}, 64'(mbits[31:0]), 64'(done_exp ? rd : 32'h0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int base;
    i_rst = 1'b1; i_ss_n = 1'b1; i_sclk = 1'b0; i_mosi = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", 64'({o_miso, o_miso_en, o_bus_valid, o_bus_access, o_bus_address,
                               o_bus_strobe}), 64'd0);
    chk("reset_wdata", 64'(o_bus_write_data), 64'd0);
    i_rst = 1'b0;
    repeat (5) @(negedge i_clk);

    // Write 02 10 DEADBEEF, ready 2 cycles after valid
    set_fb(64'h02_10_DE_AD_BE_EF_00_00);
    resp_delay = 2; resp_status = 2'b00;
    exp_q.push_back(model_req(fb));
    send_frame(56);
    chk("wr_en", 64'(en_mid), 64'd1);
    chk("wr_status", 64'(mbits[7:0]), 64'(status_byte(1'b1, 2'b00)));
    chk("wr_status_lit", 64'(mbits[7:0]), 64'h80);
    wait_txns(1, "wr_txn");
    chk("wr_req_lit", {last_acc, last_addr, last_strb, last_wdata}, {2'b11, 8'h10, 4'hF, 32'hDEADBEEF});
    chk("en_idle", 64'(o_miso_en), 64'd0);

    // Read 03 24, turnaround bits ignored, ready 3 cycles after valid
    read_frame(64'h03_24_FF_00_00_00_00_00, 3, 2'b00, 32'h12345678, 1'b1, "rd");
    chk("rd_lit", {mbits[39:32], mbits[31:0]}, {8'h80, 32'h12345678});
    wait_txns(2, "rd_txn");
    chk("rd_req_lit", {last_acc, last_addr, last_strb}, {2'b10, 8'h24, 4'h0});

    // Read with error status
    read_frame(64'h03_7C_00_00_00_00_00_00, 2, 2'b10, 32'hA5A5F00F, 1'b1, "rderr");
    chk("rderr_lit", 64'(mbits[39:32]), 64'h82);
    wait_txns(3, "rderr_txn");

    // Slow bus: response lands after the whole frame
    read_frame(64'h03_31_00_00_00_00_00_00, 900, 2'b00, 32'hCAFEF00D, 1'b0, "slow");
    chk("slow_lit", 64'(mbits[39:32]), 64'h00);
    chk("slow_valid_held", 64'(o_bus_valid), 64'd1);
    wait_txns(4, "slow_txn");

    // Abort a write after 3 data bits: nothing issued, next frame normal
    set_fb(64'h02_10_AA_00_00_00_00_00);
    send_frame(19);
    repeat (40) @(negedge i_clk);
    chk("abort_no_txn", 64'(txn_count), 64'd4);
    read_frame(64'h03_00_00_00_00_00_00_00, 2, 2'b00, 32'h0F1E2D3C, 1'b1, "after_abort");
    wait_txns(5, "after_abort_txn");

    // Invalid command: no request, miso stays low
    set_fb(64'h55_10_00_00_00_00_00_00);
    send_frame(64);
    chk("inv_miso", mbits, 64'd0);
    repeat (40) @(negedge i_clk);
    chk("inv_no_txn", 64'(txn_count), 64'd5);

    // Abort a read with its request outstanding; the next frame's request
    // must wait for the bus and the stale response must be dropped.
    set_fb(64'h03_40_00_00_00_00_00_00);
    resp_delay = 370; resp_status = 2'b11; resp_rdata = 32'hDEAD0001;
    exp_q.push_back(model_req(fb));
    send_frame(18);
    chk("pend_valid_held", 64'(o_bus_valid), 64'd1);
    read_frame(64'h03_44_00_00_00_00_00_00, 2, 2'b01, 32'h89ABCDEF, 1'b1, "pend");
    wait_txns(7, "pend_txn");
    chk("pend_req_lit", {last_acc, last_addr}, {2'b10, 8'h44});

    // Reset mid-transaction clears outputs within the same cycle
    set_fb(64'h03_55_00_00_00_00_00_00);
    resp_delay = 5000;
    exp_q.push_back(model_req(fb));
    base = txn_count;
    fork
      send_frame(64);
      begin
        int t = 0;
        while (!o_bus_valid && t < 3000) begin @(negedge i_clk); t++; end
        chk("rst_pre_valid", 64'(o_bus_valid), 64'd1);
        #2 i_rst = 1'b1;
        #1 chk("rst_outputs", 64'({o_miso, o_miso_en, o_bus_valid, o_bus_access,
                                   o_bus_address, o_bus_strobe}), 64'd0);
        chk("rst_wdata", 64'(o_bus_write_data), 64'd0);
      end
    join
    i_rst = 1'b0;
    repeat (20) @(negedge i_clk);
    chk("rst_idle", 64'({o_bus_valid, o_miso_en, txn_count == base}), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
